// File: rtl/equiv_stim_sequencer_if.sv
// Connection bundle between the equivalence-check sequencer, its run controller and the DUT pair.
// master = sequencer side, slave = controller / DUT-pair side.
interface equiv_stim_sequencer_if #(
  parameter int OUT_W  = 91,
  parameter int STIM_W = 79,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [31:0]       seed;
  logic [CNT_W-1:0]  max_cycles;
  logic [STIM_W-1:0] stim;
  logic              stim_vld;
  logic [OUT_W-1:0]  y_1;
  logic [OUT_W-1:0]  y_2;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  fail_idx;
  logic [OUT_W-1:0]  fail_y1;
  logic [OUT_W-1:0]  fail_y2;

  modport master (
    input  start, seed, max_cycles, y_1, y_2,
    output stim, stim_vld, busy, done, pass, fail_idx, fail_y1, fail_y2
  );

  modport slave (
    output start, seed, max_cycles, y_1, y_2,
    input  stim, stim_vld, busy, done, pass, fail_idx, fail_y1, fail_y2
  );
endinterface

// File: rtl/equiv_stim_sequencer.sv
// Drives LFSR stimulus into two DUT copies and compares their outputs DUT_LAT cycles later.
// Optional macro MISMATCH_CAPTURE_EN keeps y_1/y_2 of the first failing compare in fail_y1/fail_y2.
module equiv_stim_sequencer #(
  parameter int          OUT_W   = 91,
  parameter int          STIM_W  = 79,
  parameter int          CNT_W   = 16,
  parameter int          DUT_LAT = 1,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  equiv_stim_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       DRAIN_INIT = 4'(DUT_LAT - 1);

  // Fibonacci step for x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [STIM_W-1:0] stim_of(input logic [31:0] v);
    logic [95:0] rep_s;
    rep_s = {v, v, v};
    return rep_s[STIM_W-1:0];
  endfunction

  state_t              state_r, state_s;
  logic [31:0]         lfsr_r, lfsr_s;
  logic [STIM_W-1:0]   stim_r, stim_s;
  logic                stim_vld_r, stim_vld_s;
  logic [CNT_W-1:0]    remain_r, remain_s;
  logic [3:0]          drain_r, drain_s;
  logic [CNT_W-1:0]    cmp_idx_r, cmp_idx_s;
  logic [DUT_LAT-1:0]  vld_sh_r, vld_sh_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                pass_r, pass_s;
  logic [CNT_W-1:0]    fail_idx_r, fail_idx_s;
  logic                flush_s;

  logic                accept_s;
  logic                zero_run_s;
  logic [31:0]         seed_eff_s;
  logic                tail_s;
  logic                mism_s;

  assign accept_s   = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign zero_run_s = (bus.max_cycles == CNT_ZERO);
  assign seed_eff_s = (bus.seed == 32'd0) ? SEED : bus.seed;
  assign tail_s     = vld_sh_r[DUT_LAT-1];
  assign mism_s     = tail_s && (bus.y_1 != bus.y_2) &&
                      ((state_r == ST_RUN) || (state_r == ST_DRAIN));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_s = zero_run_s ? ST_DONE : ST_RUN;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (mism_s)                    state_s = ST_DONE;
        else if (remain_r == CNT_ZERO) state_s = ST_DRAIN;
        else                           state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (mism_s || (drain_r == 4'd0)) state_s = ST_DONE;
        else                             state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: vector issue, drain countdown, compare index, verdict
  always_comb begin
    lfsr_s     = lfsr_r;
    stim_s     = stim_r;
    stim_vld_s = 1'b0;
    remain_s   = remain_r;
    drain_s    = drain_r;
    cmp_idx_s  = tail_s ? (cmp_idx_r + CNT_ONE) : cmp_idx_r;
    done_s     = done_r;
    pass_s     = pass_r;
    fail_idx_s = fail_idx_r;
    flush_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          cmp_idx_s  = CNT_ZERO;
          fail_idx_s = CNT_ZERO;
          drain_s    = DRAIN_INIT;
          done_s     = zero_run_s;
          pass_s     = zero_run_s;
          if (zero_run_s) begin
            lfsr_s = seed_eff_s;
          end else begin
            lfsr_s     = lfsr_step(seed_eff_s);
            stim_s     = stim_of(seed_eff_s);
            stim_vld_s = 1'b1;
            remain_s   = bus.max_cycles - CNT_ONE;
          end
        end else begin
          done_s = done_r;
        end
      end
      ST_RUN: begin
        if (mism_s) begin
          done_s     = 1'b1;
          pass_s     = 1'b0;
          fail_idx_s = cmp_idx_r;
          flush_s    = 1'b1;
        end else if (remain_r == CNT_ZERO) begin
          drain_s = DRAIN_INIT;
        end else begin
          lfsr_s     = lfsr_step(lfsr_r);
          stim_s     = stim_of(lfsr_r);
          stim_vld_s = 1'b1;
          remain_s   = remain_r - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (mism_s) begin
          done_s     = 1'b1;
          pass_s     = 1'b0;
          fail_idx_s = cmp_idx_r;
          flush_s    = 1'b1;
        end else if (drain_r == 4'd0) begin
          done_s = 1'b1;
          pass_s = 1'b1;
        end else begin
          drain_s = drain_r - 4'd1;
        end
      end
      default: begin
        flush_s = 1'b1;
      end
    endcase

    // Valid shift lines up each vector with its DUT outputs
    vld_sh_s = {DUT_LAT{1'b0}};
    if (flush_s) begin
      vld_sh_s = {DUT_LAT{1'b0}};
    end else begin
      vld_sh_s[0] = stim_vld_r;
      for (int i = 1; i < DUT_LAT; i++) begin
        vld_sh_s[i] = vld_sh_r[i-1];
      end
    end
    busy_s = (state_s == ST_RUN) || (state_s == ST_DRAIN);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r     <= SEED;
      stim_r     <= {STIM_W{1'b0}};
      stim_vld_r <= 1'b0;
      remain_r   <= CNT_ZERO;
      drain_r    <= 4'd0;
      cmp_idx_r  <= CNT_ZERO;
      vld_sh_r   <= {DUT_LAT{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_idx_r <= CNT_ZERO;
    end else begin
      lfsr_r     <= lfsr_s;
      stim_r     <= stim_s;
      stim_vld_r <= stim_vld_s;
      remain_r   <= remain_s;
      drain_r    <= drain_s;
      cmp_idx_r  <= cmp_idx_s;
      vld_sh_r   <= vld_sh_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      pass_r     <= pass_s;
      fail_idx_r <= fail_idx_s;
    end
  end

  assign bus.stim     = stim_r;
  assign bus.stim_vld = stim_vld_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.fail_idx = fail_idx_r;

`ifdef MISMATCH_CAPTURE_EN
  logic [OUT_W-1:0] fail_y1_r;
  logic [OUT_W-1:0] fail_y2_r;

  // First qualified mismatch snapshot, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst || accept_s) begin
      fail_y1_r <= {OUT_W{1'b0}};
      fail_y2_r <= {OUT_W{1'b0}};
    end else if (mism_s) begin
      fail_y1_r <= bus.y_1;
      fail_y2_r <= bus.y_2;
    end
  end

  assign bus.fail_y1 = fail_y1_r;
  assign bus.fail_y2 = fail_y2_r;
`else
  assign bus.fail_y1 = {OUT_W{1'b0}};
  assign bus.fail_y2 = {OUT_W{1'b0}};
`endif

endmodule

// File: tb/tb_equiv_stim_sequencer.sv
// Directed bench: two sequencers (DUT_LAT 1 and 3) share controls; each gets a modelled DUT pair.
module tb_equiv_stim_sequencer;
  localparam int OUT_W = 91;
  localparam int STIM_W = 79;
  localparam int CNT_W = 16;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [31:0] seed = 32'd0;
  logic [15:0] maxc = 16'd0;
  logic        inj_a_en = 1'b0, inj_b_en = 1'b0, noise = 1'b0;
  int          inj_a = 0, inj_b = 0;
  int          n_vec = 0, n_err = 0;
  logic [STIM_W-1:0] hist [0:15];

  equiv_stim_sequencer_if #(.OUT_W(OUT_W), .STIM_W(STIM_W), .CNT_W(CNT_W)) if_a ();
  equiv_stim_sequencer_if #(.OUT_W(OUT_W), .STIM_W(STIM_W), .CNT_W(CNT_W)) if_b ();

  equiv_stim_sequencer #(.DUT_LAT(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.master));
  equiv_stim_sequencer #(.DUT_LAT(3)) u_b (.clk(clk), .rst(rst), .bus(if_b.master));

  assign if_a.start = start;  assign if_a.seed = seed;  assign if_a.max_cycles = maxc;
  assign if_b.start = start;  assign if_b.seed = seed;  assign if_b.max_cycles = maxc;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [STIM_W-1:0] rep(input logic [31:0] v);
    logic [95:0] t;
    t = {v, v, v};
    return t[STIM_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] yfun(input logic [STIM_W-1:0] s);
    return {s[11:0], s};
  endfunction

  // Modelled DUT pairs: latency 1 for u_a, latency 3 for u_b
  int vcnt_a = 0, vcnt_b = 0;
  logic [OUT_W-1:0] ya = '0;
  logic bad_a = 1'b0, vp_a = 1'b0;
  logic [OUT_W-1:0] yb [0:2];
  logic [2:0] bad_b = 3'b0, vp_b = 3'b0;
  always @(posedge clk) begin
    vcnt_a <= if_a.busy ? vcnt_a + (if_a.stim_vld ? 1 : 0) : 0;
    ya     <= yfun(if_a.stim);
    bad_a  <= if_a.stim_vld && inj_a_en && (vcnt_a == inj_a);
    vp_a   <= if_a.stim_vld;
    vcnt_b <= if_b.busy ? vcnt_b + (if_b.stim_vld ? 1 : 0) : 0;
    yb[0]  <= yfun(if_b.stim);
    yb[1]  <= yb[0];
    yb[2]  <= yb[1];
    bad_b  <= {bad_b[1:0], if_b.stim_vld && inj_b_en && (vcnt_b == inj_b)};
    vp_b   <= {vp_b[1:0], if_b.stim_vld};
  end
  assign if_a.y_1 = ya;
  assign if_a.y_2 = ya ^ {{(OUT_W-1){1'b0}}, bad_a} ^ ((noise && !vp_a) ? {OUT_W{1'b1}} : {OUT_W{1'b0}});
  assign if_b.y_1 = yb[2];
  assign if_b.y_2 = yb[2] ^ {{(OUT_W-1){1'b0}}, bad_b[2]} ^ ((noise && !vp_b[2]) ? {OUT_W{1'b1}} : {OUT_W{1'b0}});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [15:0] m);
    seed = s; maxc = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!if_a.busy && !if_b.busy) break;
      tick();
    end
    n_vec++;
    if (if_a.busy || if_b.busy) begin
      n_err++; $display("FAIL idle_timeout: busy_a=%0b busy_b=%0b, want 0 0", if_a.busy, if_b.busy);
    end
  endtask

  // Follows a run from cycle 1 after start; optional mid-run start pulse at cycle pulse_at
  task automatic watch(input logic [31:0] s, input int budget, input int pulse_at,
                       output int vld_a, output int vld_b, output int dc_a, output int dc_b,
                       output int serr);
    logic [31:0] m;
    m = (s == 32'd0) ? SEED : s;
    vld_a = 0; vld_b = 0; dc_a = -1; dc_b = -1; serr = 0;
    for (int c = 1; c <= budget; c++) begin
      start = (c == pulse_at);
      if (c == pulse_at) begin seed = 32'h0BAD_F00D; maxc = 16'd3; end
      if (if_a.stim_vld) begin
        if (vld_a < 16) hist[vld_a] = if_a.stim;
        if (if_a.stim !== rep(m)) serr++;
        m = lfsr_step(m);
        vld_a++;
      end
      if (if_b.stim_vld) vld_b++;
      if (if_a.done && dc_a < 0) dc_a = c;
      if (if_b.done && dc_b < 0) dc_b = c;
      if (dc_a >= 0 && dc_b >= 0) break;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (if_a.stim !== {STIM_W{1'b0}}) begin n_err++; $display("FAIL reset_stim: got %h want 0", if_a.stim); end
    n_vec++; if (if_a.stim_vld !== 1'b0) begin n_err++; $display("FAIL reset_stim_vld: got %b want 0", if_a.stim_vld); end
    n_vec++; if ({if_a.busy, if_a.done, if_a.pass} !== 3'b000) begin n_err++; $display("FAIL reset_flags: busy/done/pass got %b want 000", {if_a.busy, if_a.done, if_a.pass}); end
    n_vec++; if (if_a.fail_idx !== 16'd0) begin n_err++; $display("FAIL reset_fail_idx: got %0d want 0", if_a.fail_idx); end
    n_vec++; if ((if_a.fail_y1 | if_a.fail_y2) !== {OUT_W{1'b0}}) begin n_err++; $display("FAIL reset_fail_y: got %h %h want 0", if_a.fail_y1, if_a.fail_y2); end
    n_vec++; if ({if_b.busy, if_b.done, if_b.stim_vld} !== 3'b000) begin n_err++; $display("FAIL reset_lat3_flags: got %b want 000", {if_b.busy, if_b.done, if_b.stim_vld}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_seed_default();
    wait_idle();
    do_start(32'd0, 16'd3);
    n_vec++; if (if_a.stim_vld !== 1'b1 || if_a.stim !== rep(32'hACE1_0001)) begin n_err++; $display("FAIL seed0_vec0: got vld=%b %h want 1 %h", if_a.stim_vld, if_a.stim, rep(32'hACE1_0001)); end
    tick();
    n_vec++; if (if_a.stim !== rep(32'h59C2_0003)) begin n_err++; $display("FAIL seed0_vec1: got %h want %h", if_a.stim, rep(32'h59C2_0003)); end
    tick();
    n_vec++; if (if_a.stim !== rep(32'hB384_0006)) begin n_err++; $display("FAIL seed0_vec2: got %h want %h", if_a.stim, rep(32'hB384_0006)); end
    tick();
    n_vec++; if (if_a.stim_vld !== 1'b0 || if_a.busy !== 1'b1 || if_a.stim !== rep(32'hB384_0006)) begin n_err++; $display("FAIL seed0_drain: got vld=%b busy=%b stim=%h want 0 1 held", if_a.stim_vld, if_a.busy, if_a.stim); end
    tick();
    n_vec++; if ({if_a.done, if_a.pass, if_a.busy} !== 3'b110) begin n_err++; $display("FAIL seed0_done: done/pass/busy got %b want 110", {if_a.done, if_a.pass, if_a.busy}); end
  endtask

  task automatic test_identical();
    int va, vb, da, db, se;
    wait_idle();
    noise = 1'b1;
    do_start(32'hDEAD_BEEF, 16'd100);
    watch(32'hDEAD_BEEF, 400, -1, va, vb, da, db, se);
    n_vec++; if (va != 100) begin n_err++; $display("FAIL ident_vld_count: got %0d want 100", va); end
    n_vec++; if (da != 102) begin n_err++; $display("FAIL ident_done_cycle: got %0d want 102", da); end
    n_vec++; if (se != 0) begin n_err++; $display("FAIL ident_stim_stream: got %0d bad vectors want 0", se); end
    n_vec++; if (if_a.pass !== 1'b1 || if_a.fail_idx !== 16'd0) begin n_err++; $display("FAIL ident_pass: got pass=%b idx=%0d want 1 0", if_a.pass, if_a.fail_idx); end
    n_vec++; if (db != 104 || if_b.pass !== 1'b1) begin n_err++; $display("FAIL ident_lat3: got done_cycle=%0d pass=%b want 104 1", db, if_b.pass); end
    noise = 1'b0;
  endtask

  task automatic test_mismatch();
    int va, vb, da, db, se;
    logic [31:0] m;
    logic [OUT_W-1:0] exp_y1;
    wait_idle();
    inj_a_en = 1'b1; inj_a = 37;
    do_start(32'hC0FF_EE00, 16'd100);
    watch(32'hC0FF_EE00, 400, -1, va, vb, da, db, se);
    n_vec++; if (da != 40) begin n_err++; $display("FAIL mism_done_cycle: got %0d want 40", da); end
    n_vec++; if (va != 39) begin n_err++; $display("FAIL mism_vld_count: got %0d want 39", va); end
    n_vec++; if (if_a.pass !== 1'b0 || if_a.fail_idx !== 16'd37) begin n_err++; $display("FAIL mism_verdict: got pass=%b idx=%0d want 0 37", if_a.pass, if_a.fail_idx); end
    m = 32'hC0FF_EE00;
    for (int i = 0; i < 37; i++) m = lfsr_step(m);
    exp_y1 = yfun(rep(m));
`ifdef MISMATCH_CAPTURE_EN
    n_vec++; if (if_a.fail_y1 !== exp_y1 || if_a.fail_y2 !== (exp_y1 ^ {{(OUT_W-1){1'b0}}, 1'b1})) begin n_err++; $display("FAIL mism_capture: got %h %h want %h and ^1", if_a.fail_y1, if_a.fail_y2, exp_y1); end
`else
    n_vec++; if ((if_a.fail_y1 | if_a.fail_y2) !== {OUT_W{1'b0}}) begin n_err++; $display("FAIL mism_no_capture: got %h %h want 0 (ref %h)", if_a.fail_y1, if_a.fail_y2, exp_y1); end
`endif
    inj_a_en = 1'b0;
  endtask

  task automatic test_zero_cycles();
    int seen;
    wait_idle();
    do_start(32'h0000_0005, 16'd0);
    n_vec++; if ({if_a.done, if_a.pass, if_a.busy, if_a.stim_vld} !== 4'b1100) begin n_err++; $display("FAIL zero_done: done/pass/busy/vld got %b want 1100", {if_a.done, if_a.pass, if_a.busy, if_a.stim_vld}); end
    n_vec++; if (if_a.fail_idx !== 16'd0 || if_a.fail_y1 !== {OUT_W{1'b0}}) begin n_err++; $display("FAIL zero_cleared: got idx=%0d y1=%h want 0 0", if_a.fail_idx, if_a.fail_y1); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_a.stim_vld || if_b.stim_vld) seen++;
      tick();
    end
    n_vec++; if (seen != 0 || if_a.done !== 1'b1) begin n_err++; $display("FAIL zero_no_vectors: got %0d vld cycles done=%b want 0 1", seen, if_a.done); end
  endtask

  task automatic test_start_ignored();
    int va, vb, da, db, se;
    wait_idle();
    do_start(32'h0000_00A5, 16'd20);
    n_vec++; if (if_a.done !== 1'b0 || if_a.busy !== 1'b1) begin n_err++; $display("FAIL restart_clears_done: got done=%b busy=%b want 0 1", if_a.done, if_a.busy); end
    watch(32'h0000_00A5, 200, 5, va, vb, da, db, se);
    n_vec++; if (va != 20 || da != 22) begin n_err++; $display("FAIL midrun_start: got vld=%0d done_cycle=%0d want 20 22", va, da); end
    n_vec++; if (se != 0 || if_a.pass !== 1'b1) begin n_err++; $display("FAIL midrun_stream: got %0d bad vectors pass=%b want 0 1", se, if_a.pass); end
    wait_idle();
    do_start(32'h1111_2222, 16'd50);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    n_vec++; if ({if_a.busy, if_a.done, if_a.pass, if_a.stim_vld} !== 4'b0000) begin n_err++; $display("FAIL midrun_reset: busy/done/pass/vld got %b want 0000", {if_a.busy, if_a.done, if_a.pass, if_a.stim_vld}); end
    rst = 1'b0;
    tick();
    n_vec++; if (if_b.busy !== 1'b0 || if_b.done !== 1'b0) begin n_err++; $display("FAIL midrun_reset_lat3: got busy=%b done=%b want 0 0", if_b.busy, if_b.done); end
  endtask

  task automatic test_lat3_repeat();
    int va, vb, da, db, se, diff;
    logic [STIM_W-1:0] h1 [0:15];
    wait_idle();
    do_start(32'h1234_5678, 16'd10);
    watch(32'h1234_5678, 100, -1, va, vb, da, db, se);
    for (int i = 0; i < 10; i++) h1[i] = hist[i];
    n_vec++; if (da != 12 || db != 14) begin n_err++; $display("FAIL lat_done_cycles: got %0d %0d want 12 14", da, db); end
    n_vec++; if (va != 10 || se != 0) begin n_err++; $display("FAIL lat_run1_stream: got vld=%0d bad=%0d want 10 0", va, se); end
    wait_idle();
    inj_b_en = 1'b1; inj_b = 4;
    do_start(32'h1234_5678, 16'd10);
    watch(32'h1234_5678, 100, -1, va, vb, da, db, se);
    diff = 0;
    for (int i = 0; i < 10; i++) if (hist[i] !== h1[i]) diff++;
    n_vec++; if (diff != 0 || va != 10) begin n_err++; $display("FAIL lat_repeat_stim: got %0d differing of %0d want 0 of 10", diff, va); end
    n_vec++; if (db != 9 || vb != 8) begin n_err++; $display("FAIL lat3_mism_timing: got done_cycle=%0d vld=%0d want 9 8", db, vb); end
    n_vec++; if (if_b.pass !== 1'b0 || if_b.fail_idx !== 16'd4) begin n_err++; $display("FAIL lat3_verdict: got pass=%b idx=%0d want 0 4", if_b.pass, if_b.fail_idx); end
    n_vec++; if (da != 12 || if_a.pass !== 1'b1) begin n_err++; $display("FAIL lat1_clean: got done_cycle=%0d pass=%b want 12 1", da, if_a.pass); end
    inj_b_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seed_default();
    test_identical();
    test_mismatch();
    test_zero_cycles();
    test_start_ignored();
    test_lat3_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
